// File: rtl/viterbi_decoder3_pkg.sv
// Shared constants and types for the three-state hard-decision Viterbi decoder.
// Optional feature macro: VITERBI_NORMALIZE_EN (see viterbi_decoder3.sv).
package viterbi_pkg;

   localparam int N_STATES = 3;
   localparam int N_OBS    = 3;
   localparam int MAX_LEN  = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FORWARD  = 2'd1,
      BACKWARD = 2'd2,
      DONE     = 2'd3
   } fsm_state_e;

   typedef logic [1:0] state_t;
   typedef logic [1:0] sym_t;

   // Symbol 3 is not a legal observation; it is folded onto symbol 2.
   function automatic sym_t clamp_obs(input sym_t o);
      return (o == 2'd3) ? 2'd2 : o;
   endfunction

endpackage

// File: rtl/viterbi_decoder3_if.sv
// Host-side bus of the Viterbi decoder: decode control, observation stream, results.
// Optional feature macro: none used here.
//
// Observation stream: there is no ready. While the decoder is in FORWARD, every
// cycle with obs_valid=1 consumes obs_in as the next observation; obs_valid in
// any other state is ignored. start is a one-cycle pulse, honoured only in
// IDLE/DONE, and carries observation 0 on obs_in together with length.
interface viterbi_decoder3_if;
   import viterbi_pkg::*;

   logic       start;
   logic [2:0] length;
   sym_t       obs_in;
   logic       obs_valid;
   state_t     path_0, path_1, path_2, path_3;
   state_t     path_4, path_5, path_6, path_7;
   logic       done;

   modport master (
      output start, length, obs_in, obs_valid,
      input  path_0, path_1, path_2, path_3, path_4, path_5, path_6, path_7, done
   );

   modport slave (
      input  start, length, obs_in, obs_valid,
      output path_0, path_1, path_2, path_3, path_4, path_5, path_6, path_7, done
   );

endinterface

// File: rtl/viterbi_decoder3_acs.sv
// Add-compare-select for one destination state: picks the best predecessor
// (lowest index wins ties) and adds the emission term.
// Optional feature macro: none used here.
module viterbi_acs
   import viterbi_pkg::*;
#(
   parameter int W = 16
) (
   input  logic signed [W+4:0] d0,
   input  logic signed [W+4:0] d1,
   input  logic signed [W+4:0] d2,
   input  logic signed [W-1:0] a0,
   input  logic signed [W-1:0] a1,
   input  logic signed [W-1:0] a2,
   input  logic signed [W-1:0] b,
   output logic signed [W+4:0] delta_new,
   output state_t              arg
);

   logic signed [W+4:0] s0, s1, s2, best;

   // Candidate sums, strict-greater compare so equal scores keep the lower index.
   always_comb begin
      s0   = d0 + (W+5)'(a0);
      s1   = d1 + (W+5)'(a1);
      s2   = d2 + (W+5)'(a2);
      best = s0;
      arg  = 2'd0;
      if (s1 > best) begin
         best = s1;
         arg  = 2'd1;
      end
      if (s2 > best) begin
         best = s2;
         arg  = 2'd2;
      end
      delta_new = best + (W+5)'(b);
   end

endmodule

// File: rtl/viterbi_decoder3.sv
// Three-state, three-symbol Viterbi decoder: forward ACS recursion with
// back-pointer storage, then traceback onto path_0..path_7.
// Optional feature macro: VITERBI_NORMALIZE_EN -- subtract the max delta after
// every delta update so the best registered delta is always 0.
module viterbi_decoder3
   import viterbi_pkg::*;
#(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   viterbi_decoder3_if.slave   bus,
   input  logic signed [W-1:0] logA_0, logA_1, logA_2,
   input  logic signed [W-1:0] logA_3, logA_4, logA_5,
   input  logic signed [W-1:0] logA_6, logA_7, logA_8,
   input  logic signed [W-1:0] logC_0, logC_1, logC_2,
   input  logic signed [W-1:0] logB_0, logB_1, logB_2,
   input  logic signed [W-1:0] logB_3, logB_4, logB_5,
   input  logic signed [W-1:0] logB_6, logB_7, logB_8,
   output logic [1:0]          dbg_state
);

   localparam int DW = W + 5;

   localparam logic [1:0] ST_IDLE     = IDLE;
   localparam logic [1:0] ST_FORWARD  = FORWARD;
   localparam logic [1:0] ST_BACKWARD = BACKWARD;
   localparam logic [1:0] ST_DONE     = DONE;

   logic [1:0]           state;
   logic [2:0]           t, back_t, len_q;
   logic                 bt_first, done_q;
   logic signed [DW-1:0] delta_0, delta_1, delta_2;
   state_t               path_q [MAX_LEN];
   state_t               bp     [MAX_LEN][N_STATES];

   logic signed [W-1:0]  log_a [9];
   logic signed [W-1:0]  log_b [9];
   logic signed [W-1:0]  log_c [3];
   logic signed [W-1:0]  b_sel [3];
   logic signed [DW-1:0] d_cur [3];
   logic signed [DW-1:0] acs_d [3];
   state_t               acs_arg [3];
   logic signed [DW-1:0] upd_raw [3];
   logic signed [DW-1:0] upd [3];
   state_t               fin;
   sym_t                 obs_c;

   assign log_a = '{logA_0, logA_1, logA_2, logA_3, logA_4, logA_5, logA_6, logA_7, logA_8};
   assign log_b = '{logB_0, logB_1, logB_2, logB_3, logB_4, logB_5, logB_6, logB_7, logB_8};
   assign log_c = '{logC_0, logC_1, logC_2};
   assign d_cur = '{delta_0, delta_1, delta_2};

   // Emission term per state for the current (clamped) symbol, the candidate
   // delta update (init on start, ACS in FORWARD) and the final-state argmax.
   always_comb begin
      obs_c = clamp_obs(bus.obs_in);
      for (int j = 0; j < N_STATES; j++) begin
         b_sel[j]   = log_b[4'(3 * j) + {2'b00, obs_c}];
         upd_raw[j] = (state == ST_FORWARD) ? acs_d[j]
                                            : DW'(log_c[j]) + DW'(b_sel[j]);
      end
`ifdef VITERBI_NORMALIZE_EN
      begin
         logic signed [DW-1:0] m;
         m = upd_raw[0];
         if (upd_raw[1] > m) m = upd_raw[1];
         if (upd_raw[2] > m) m = upd_raw[2];
         for (int j = 0; j < N_STATES; j++) upd[j] = upd_raw[j] - m;
      end
`else
      for (int j = 0; j < N_STATES; j++) upd[j] = upd_raw[j];
`endif
      fin = 2'd0;
      if (d_cur[1] > d_cur[0]) fin = 2'd1;
      if (d_cur[2] > d_cur[fin]) fin = 2'd2;
   end

   for (genvar j = 0; j < N_STATES; j++) begin : g_acs
      viterbi_acs #(.W(W)) u_acs (
         .d0        (delta_0),
         .d1        (delta_1),
         .d2        (delta_2),
         .a0        (log_a[j]),
         .a1        (log_a[3 + j]),
         .a2        (log_a[6 + j]),
         .b         (b_sel[j]),
         .delta_new (acs_d[j]),
         .arg       (acs_arg[j])
      );
   end

   // Control FSM plus delta, back-pointer and path registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         t        <= 3'd0;
         back_t   <= 3'd0;
         len_q    <= 3'd0;
         bt_first <= 1'b0;
         done_q   <= 1'b0;
         delta_0  <= '0;
         delta_1  <= '0;
         delta_2  <= '0;
         for (int i = 0; i < MAX_LEN; i++) begin
            path_q[i] <= 2'd0;
            for (int j = 0; j < N_STATES; j++) bp[i][j] <= 2'd0;
         end
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  len_q   <= (bus.length == 3'd0) ? 3'd1 : bus.length;
                  done_q  <= 1'b0;
                  for (int i = 0; i < MAX_LEN; i++) path_q[i] <= 2'd0;
                  delta_0 <= upd[0];
                  delta_1 <= upd[1];
                  delta_2 <= upd[2];
                  t       <= 3'd1;
                  if (bus.length <= 3'd1) begin
                     state    <= ST_BACKWARD;
                     bt_first <= 1'b1;
                  end else begin
                     state <= ST_FORWARD;
                  end
               end
            end
            ST_FORWARD: begin
               if (bus.obs_valid) begin
                  for (int j = 0; j < N_STATES; j++) bp[t][j] <= acs_arg[j];
                  delta_0 <= upd[0];
                  delta_1 <= upd[1];
                  delta_2 <= upd[2];
                  t       <= t + 3'd1;
                  if (t == len_q - 3'd1) begin
                     state    <= ST_BACKWARD;
                     bt_first <= 1'b1;
                  end
               end
            end
            ST_BACKWARD: begin
               if (bt_first) begin
                  path_q[len_q - 3'd1] <= fin;
                  back_t               <= len_q - 3'd1;
                  bt_first             <= 1'b0;
               end else if (back_t != 3'd0) begin
                  path_q[back_t - 3'd1] <= bp[back_t][path_q[back_t]];
                  back_t                <= back_t - 3'd1;
               end else begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.path_0 = path_q[0];
   assign bus.path_1 = path_q[1];
   assign bus.path_2 = path_q[2];
   assign bus.path_3 = path_q[3];
   assign bus.path_4 = path_q[4];
   assign bus.path_5 = path_q[5];
   assign bus.path_6 = path_q[6];
   assign bus.path_7 = path_q[7];
   assign bus.done   = done_q;
   assign dbg_state  = state;

endmodule

// File: tb/tb_viterbi_decoder3.sv
// Directed bench for viterbi_decoder3 with hand-computed expectations.
// Optional feature macro: VITERBI_NORMALIZE_EN changes the expected delta values.
module tb_viterbi_decoder3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   viterbi_decoder3_if bus ();

   logic signed [15:0] log_a [9];
   logic signed [15:0] log_b [9];
   logic signed [15:0] log_c [3];
   logic [1:0]         dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] exp_q [$];

   // Hand-derived with logA diag -5/off -50, logC -10, logB diag -1/off -50:
   // init obs0 -> [-11,-60,-60]; step obs1 -> [-66,-62,-111];
   // all-zero obs: delta_0 = -11, -17, -23. Normalized runs shift by the max.
`ifdef VITERBI_NORMALIZE_EN
   localparam int E_D0 = -4, E_D1 = 0, E_D2 = -49, E_FIN0 = 0;
`else
   localparam int E_D0 = -66, E_D1 = -62, E_D2 = -111, E_FIN0 = -23;
`endif

   // Clock and reset
   always #5 clk = ~clk;

   viterbi_decoder3 #(.W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .logA_0    (log_a[0]), .logA_1 (log_a[1]), .logA_2 (log_a[2]),
      .logA_3    (log_a[3]), .logA_4 (log_a[4]), .logA_5 (log_a[5]),
      .logA_6    (log_a[6]), .logA_7 (log_a[7]), .logA_8 (log_a[8]),
      .logC_0    (log_c[0]), .logC_1 (log_c[1]), .logC_2 (log_c[2]),
      .logB_0    (log_b[0]), .logB_1 (log_b[1]), .logB_2 (log_b[2]),
      .logB_3    (log_b[3]), .logB_4 (log_b[4]), .logB_5 (log_b[5]),
      .logB_6    (log_b[6]), .logB_7 (log_b[7]), .logB_8 (log_b[8]),
      .dbg_state (dbg_state)
   );

   // Checker
   task automatic check(input string tag, input int got, input int want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   function automatic logic [15:0] packed_paths();
      return {bus.path_7, bus.path_6, bus.path_5, bus.path_4,
              bus.path_3, bus.path_2, bus.path_1, bus.path_0};
   endfunction

   // Scoreboard: compare all eight path outputs against the next expected word.
   task automatic check_paths(input string tag);
      logic [15:0] want;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 1, 0);
      end else begin
         want = exp_q.pop_front();
         check(tag, int'(packed_paths()), int'(want));
      end
   endtask

   // Driver tasks
   task automatic set_common();
      for (int i = 0; i < 3; i++) begin
         log_c[i] = -16'sd10;
         for (int j = 0; j < 3; j++) begin
            log_a[3*i+j] = (i == j) ? -16'sd5 : -16'sd50;
            log_b[3*i+j] = (i == j) ? -16'sd1 : -16'sd50;
         end
      end
   endtask

   task automatic set_flat(input logic signed [15:0] v);
      for (int i = 0; i < 9; i++) begin
         log_a[i] = v;
         log_b[i] = v;
      end
      for (int i = 0; i < 3; i++) log_c[i] = v;
   endtask

   task automatic start_decode(input logic [2:0] len, input logic [1:0] o);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.length = len;
      bus.obs_in = o;
      @(negedge clk);
      bus.start  = 1'b0;
   endtask

   task automatic send_obs(input logic [1:0] o, input int gap);
      repeat (gap) @(negedge clk);
      bus.obs_valid = 1'b1;
      bus.obs_in    = o;
      @(negedge clk);
      bus.obs_valid = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles, output int n);
      n = 0;
      while (!bus.done && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (!bus.done) check("done_timeout", 0, 1);
   endtask

   // Reference decode: length 3, obs 0,1,2 with gaps between valid pulses.
   task automatic decode_ref(input bit check_mid, input bit poke_start, output int lat);
      start_decode(3'd3, 2'd0);
      send_obs(2'd1, 3);
      if (check_mid) begin
         check("ref_step1_delta0", int'(dut.delta_0), E_D0);
         check("ref_step1_delta1", int'(dut.delta_1), E_D1);
         check("ref_step1_delta2", int'(dut.delta_2), E_D2);
         check("ref_step1_t", int'(dut.t), 2);
      end
      send_obs(2'd2, 2);
      if (poke_start) begin
         bus.start  = 1'b1;
         bus.length = 3'd1;
         bus.obs_in = 2'd0;
         @(negedge clk);
         bus.start  = 1'b0;
      end
      wait_done(20, lat);
   endtask

   initial begin
      int lat;
      bus.start     = 1'b0;
      bus.length    = 3'd0;
      bus.obs_in    = 2'd0;
      bus.obs_valid = 1'b0;
      set_common();

      repeat (3) @(negedge clk);
      check("rst_state", int'(dbg_state), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_t", int'(dut.t), 0);
      check("rst_delta0", int'(dut.delta_0), 0);
      exp_q.push_back(16'h0000);
      check_paths("rst_paths");
      rst_n = 1'b1;

      // Test 1: reference decode -> path [0,1,2], done L+1 cycles after BACKWARD entry
      decode_ref(1'b1, 1'b0, lat);
      check("t1_latency", lat, 4);
      check("t1_done", int'(bus.done), 1);
      exp_q.push_back(16'h0024);
      check_paths("t1_paths");

      // Test 2: all-zero observations; start from DONE clears done and paths
      start_decode(3'd3, 2'd0);
      check("t2_done_cleared", int'(bus.done), 0);
      exp_q.push_back(16'h0000);
      check_paths("t2_paths_cleared");
      send_obs(2'd0, 0);
      send_obs(2'd0, 1);
      wait_done(20, lat);
      exp_q.push_back(16'h0000);
      check_paths("t2_paths");
      check("t2_final_delta0", int'(dut.delta_0), E_FIN0);

      // Test 3: length 1, obs 2 -> straight to BACKWARD, path_0 = 2
      start_decode(3'd1, 2'd2);
      check("t3_state_backward", int'(dbg_state), 2);
      wait_done(20, lat);
      check("t3_latency", lat, 2);
      exp_q.push_back(16'h0002);
      check_paths("t3_paths");

      // Test 4: all parameters equal -> ties resolve to state 0
      set_flat(-16'sd7);
      start_decode(3'd4, 2'd1);
      send_obs(2'd2, 0);
      send_obs(2'd3, 1);
      send_obs(2'd0, 0);
      wait_done(20, lat);
      check("t4_latency", lat, 5);
      exp_q.push_back(16'h0000);
      check_paths("t4_paths");

      // Test 5: reset in FORWARD after one step, then a clean decode
      set_common();
      start_decode(3'd3, 2'd0);
      send_obs(2'd1, 1);
      check("t5_pre_state", int'(dbg_state), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_state", int'(dbg_state), 0);
      check("t5_rst_t", int'(dut.t), 0);
      check("t5_rst_delta1", int'(dut.delta_1), 0);
      check("t5_rst_done", int'(bus.done), 0);
      exp_q.push_back(16'h0000);
      check_paths("t5_rst_paths");
      @(negedge clk);
      rst_n = 1'b1;
      decode_ref(1'b0, 1'b0, lat);
      exp_q.push_back(16'h0024);
      check_paths("t5_paths");

      // Test 6: obs_valid in IDLE and start in BACKWARD are ignored
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send_obs(2'd2, 0);
      send_obs(2'd1, 1);
      check("t6_idle_state", int'(dbg_state), 0);
      check("t6_idle_t", int'(dut.t), 0);
      decode_ref(1'b0, 1'b1, lat);
      check("t6_latency", lat, 3);
      exp_q.push_back(16'h0024);
      check_paths("t6_paths");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
